mdio_slave_responder: RTL and testbench

- PHY-side MDIO responder: the target end of our MDIO management link, answering frames issued by the MAC-side MDIO master.
- Decodes Clause-22 frames on mdio, matches PHYAD, and services reads and writes against an internal 32x16 register file.
- Used as a PHY register model in system simulation and as a management slave in FPGA loopback builds.

---
 rtl/mdio_slave_responder.sv | 218 +++++++++++++++++++++
 tb/tb_mdio_slave_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_slave_responder.sv
//------------------------------------------------------------------------------
// Module   : mdio_slave_responder
// Function : PHY-side Clause-22 MDIO target with a 32x16 register file.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mdio_slave_responder #(
  parameter int          PRE_BITS = 1,
  parameter logic [15:0] PHY_ID1  = 16'h0022,
  parameter logic [15:0] PHY_ID2  = 16'h1622
) (
  input  logic        mdc,
  input  logic        rst_n,
  inout  wire         mdio,
  input  logic [4:0]  phy_addr,
  output logic        wr_en,
  output logic [4:0]  wr_regad,
  output logic [15:0] wr_data,
  output logic        rd_en,
  output logic        frame_err
);

  localparam logic [3:0] c_IDLE  = 4'd0;
  localparam logic [3:0] c_ST2   = 4'd1;
  localparam logic [3:0] c_OP1   = 4'd2;
  localparam logic [3:0] c_OP2   = 4'd3;
  localparam logic [3:0] c_ADDR  = 4'd4;
  localparam logic [3:0] c_TA1   = 4'd5;
  localparam logic [3:0] c_TA2   = 4'd6;
  localparam logic [3:0] c_WDATA = 4'd7;
  localparam logic [3:0] c_RDATA = 4'd8;
  localparam logic [3:0] c_SKIP  = 4'd9;

  localparam logic [5:0] c_PRE     = 6'(PRE_BITS);
  localparam logic [5:0] c_ONE_SAT = 6'd32;

  logic [3:0]  r_state;
  logic [5:0]  r_ones;
  logic [4:0]  r_cnt;
  logic [14:0] r_shift;
  logic [15:0] r_tx;
  logic        r_op1;
  logic        r_is_wr;
  logic        r_ta1_ok;
  logic [4:0]  r_regad;
  logic        r_mdio_o;
  logic        r_mdio_oe;
  logic [15:0] r_regs [32];

  logic        w_in;
  logic [9:0]  w_addr10;
  logic [15:0] w_wdata;
  logic        w_commit;
  logic        w_ro_reg;

  assign mdio     = r_mdio_oe ? r_mdio_o : 1'bz;
  assign w_in     = mdio;
  assign w_addr10 = {r_shift[8:0], w_in};
  assign w_wdata  = {r_shift[14:0], w_in};
  assign w_commit = (r_state == c_WDATA) && (r_cnt == 5'd15);
  assign w_ro_reg = (r_regad == 5'd2) || (r_regad == 5'd3);

  // Registers 2 and 3 hold the PHY identifier and ignore writes.
  always_ff @(posedge mdc or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 16'h0000;
      end
      r_regs[2] <= PHY_ID1;
      r_regs[3] <= PHY_ID2;
    end else if (w_commit && !w_ro_reg) begin
      r_regs[r_regad] <= w_wdata;
    end
  end

  always_ff @(posedge mdc or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_ones    <= 6'd0;
      r_cnt     <= 5'd0;
      r_shift   <= 15'd0;
      r_tx      <= 16'd0;
      r_op1     <= 1'b0;
      r_is_wr   <= 1'b0;
      r_ta1_ok  <= 1'b0;
      r_regad   <= 5'd0;
      r_mdio_o  <= 1'b1;
      r_mdio_oe <= 1'b0;
      wr_en     <= 1'b0;
      wr_regad  <= 5'd0;
      wr_data   <= 16'd0;
      rd_en     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_in) begin
            if (r_ones != c_ONE_SAT) begin
              r_ones <= r_ones + 6'd1;
            end
          end else begin
            r_ones <= 6'd0;
            if (r_ones >= c_PRE) begin
              r_state <= c_ST2;
            end
          end
        end
        c_ST2: begin
          if (w_in) begin
            r_state <= c_OP1;
          end else begin
            frame_err <= 1'b1;
            r_state   <= c_IDLE;
          end
        end
        c_OP1: begin
          r_op1   <= w_in;
          r_state <= c_OP2;
        end
        c_OP2: begin
          if (r_op1 ^ w_in) begin
            r_is_wr <= w_in;
            r_cnt   <= 5'd0;
            r_state <= c_ADDR;
          end else begin
            frame_err <= 1'b1;
            r_cnt     <= 5'd27;
            r_state   <= c_SKIP;
          end
        end
        c_ADDR: begin
          r_shift <= {r_shift[13:0], w_in};
          if (r_cnt == 5'd9) begin
            if (w_addr10[9:5] == phy_addr) begin
              r_regad <= w_addr10[4:0];
              r_state <= c_TA1;
            end else begin
              r_cnt   <= 5'd17;
              r_state <= c_SKIP;
            end
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        c_TA1: begin
          if (r_is_wr) begin
            r_ta1_ok <= w_in;
          end else begin
            // Take over the bus here so TA2 is driven low for a full period.
            rd_en     <= 1'b1;
            r_mdio_oe <= 1'b1;
            r_mdio_o  <= 1'b0;
            r_tx      <= r_regs[r_regad];
          end
          r_state <= c_TA2;
        end
        c_TA2: begin
          if (r_is_wr) begin
            if (r_ta1_ok && !w_in) begin
              r_cnt   <= 5'd0;
              r_state <= c_WDATA;
            end else begin
              frame_err <= 1'b1;
              r_cnt     <= 5'd15;
              r_state   <= c_SKIP;
            end
          end else begin
            r_mdio_o <= r_tx[15];
            r_tx     <= {r_tx[14:0], 1'b0};
            r_cnt    <= 5'd0;
            r_state  <= c_RDATA;
          end
        end
        c_WDATA: begin
          r_shift <= w_wdata[14:0];
          if (r_cnt == 5'd15) begin
            wr_en    <= 1'b1;
            wr_regad <= r_regad;
            wr_data  <= w_wdata;
            r_state  <= c_IDLE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        c_RDATA: begin
          if (r_cnt == 5'd15) begin
            r_mdio_oe <= 1'b0;
            r_mdio_o  <= 1'b1;
            r_state   <= c_IDLE;
          end else begin
            r_mdio_o <= r_tx[15];
            r_tx     <= {r_tx[14:0], 1'b0};
            r_cnt    <= r_cnt + 5'd1;
          end
        end
        c_SKIP: begin
          if (r_cnt == 5'd0) begin
            r_state <= c_IDLE;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        default: begin
          r_state   <= c_IDLE;
          r_mdio_oe <= 1'b0;
          r_mdio_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdio_slave_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_mdio_slave_responder
// Function : Directed bench for mdio_slave_responder (PRE_BITS=1 and 32).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mdio_slave_responder;

  logic mdc   = 1'b0;
  logic rst_n = 1'b0;
  logic tb_o  = 1'b1;
  logic tb_oe = 1'b0;
  logic sel2  = 1'b0;
  wire  mdio;
  wire  mdio2;

  pullup (mdio);
  pullup (mdio2);

  // The second responder sees a driven 0 while unselected so its preamble count stays at zero.
  assign mdio  = (!sel2 && tb_oe) ? tb_o : 1'bz;
  assign mdio2 = sel2 ? (tb_oe ? tb_o : 1'bz) : 1'b0;

  logic        wr_en1, rd_en1, frame_err1, wr_en2, rd_en2, frame_err2;
  logic [4:0]  wr_regad1, wr_regad2;
  logic [15:0] wr_data1, wr_data2;

  mdio_slave_responder #(.PRE_BITS(1)) dut1 (
    .mdc(mdc), .rst_n(rst_n), .mdio(mdio), .phy_addr(5'h01),
    .wr_en(wr_en1), .wr_regad(wr_regad1), .wr_data(wr_data1),
    .rd_en(rd_en1), .frame_err(frame_err1)
  );

  mdio_slave_responder #(.PRE_BITS(32)) dut2 (
    .mdc(mdc), .rst_n(rst_n), .mdio(mdio2), .phy_addr(5'h02),
    .wr_en(wr_en2), .wr_regad(wr_regad2), .wr_data(wr_data2),
    .rd_en(rd_en2), .frame_err(frame_err2)
  );

  always #5 mdc = ~mdc;

  wire  w_bus = sel2 ? mdio2 : mdio;
  logic w_oe;
  logic w_rd;
  logic w_wr;
  assign w_oe = sel2 ? dut2.r_mdio_oe : dut1.r_mdio_oe;
  assign w_rd = sel2 ? rd_en2 : rd_en1;
  assign w_wr = sel2 ? wr_en2 : wr_en1;

  int drv1 = 0, drv2 = 0, wr1 = 0, rd1 = 0, err1 = 0, wr2 = 0, rd2 = 0, err2 = 0, excl = 0;

  always @(negedge mdc) begin
    if (dut1.r_mdio_oe) drv1++;
    if (dut2.r_mdio_oe) drv2++;
    if (wr_en1) wr1++;
    if (rd_en1) rd1++;
    if (frame_err1) err1++;
    if (wr_en2) wr2++;
    if (rd_en2) rd2++;
    if (frame_err2) err2++;
    if ((32'(wr_en1) + 32'(rd_en1) + 32'(frame_err1)) > 1) excl++;
    if ((32'(wr_en2) + 32'(rd_en2) + 32'(frame_err2)) > 1) excl++;
  end

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge mdc);
    tb_oe = 1'b1;
    tb_o  = b;
    @(posedge mdc);
    #1;
  endtask

  task automatic send_hdr(input int pre, input logic [1:0] op, input logic [4:0] pa,
                          input logic [4:0] ra);
    logic [13:0] hdr;
    hdr = {2'b01, op, pa, ra};
    for (int i = 0; i < pre; i++) send_bit(1'b1);
    for (int i = 13; i >= 0; i--) send_bit(hdr[i]);
  endtask

  task automatic release_bus(input int n);
    @(negedge mdc);
    tb_oe = 1'b0;
    repeat (n) @(negedge mdc);
  endtask

  task automatic write_frame(input int pre, input logic [4:0] pa, input logic [4:0] ra,
                             input logic [1:0] ta, input logic [15:0] d,
                             output logic wr_before, output logic wr_at_d0);
    send_hdr(pre, 2'b01, pa, ra);
    send_bit(ta[1]);
    send_bit(ta[0]);
    wr_before = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (i == 0) wr_before = w_wr;
      send_bit(d[i]);
    end
    wr_at_d0 = w_wr;
    release_bus(2);
  endtask

  task automatic read_frame(input int pre, input logic [4:0] pa, input logic [4:0] ra,
                            input int abort_at, output logic [15:0] d, output logic ta2,
                            output logic rd_pulse, output logic oe_ta1, output logic oe_end);
    send_hdr(pre, 2'b10, pa, ra);
    @(negedge mdc);
    tb_oe = 1'b0;
    #1 oe_ta1 = w_oe;
    @(posedge mdc);
    #1 rd_pulse = w_rd;
    @(negedge mdc);
    ta2 = w_bus;
    d = 16'h0000;
    oe_end = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge mdc);
      d[15-i] = w_bus;
      if (i == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_read_oe", 32'(w_oe), 32'h0);
        check("rst_mid_read_bus", 32'(w_bus), 32'h1);
        return;
      end
    end
    @(posedge mdc);
    #1 oe_end = w_oe;
  endtask

  initial begin
    logic [15:0] d;
    logic        ta2, rdp, oe1, oe2, wb, wa;
    int          s_drv, s_wr, s_rd, s_err;

    repeat (3) @(posedge mdc);
    #1;
    check("reset_wr_en", 32'(wr_en1), 32'h0);
    check("reset_rd_en", 32'(rd_en1), 32'h0);
    check("reset_frame_err", 32'(frame_err1), 32'h0);
    check("reset_wr_regad", 32'(wr_regad1), 32'h0);
    check("reset_wr_data", 32'(wr_data1), 32'h0);
    check("reset_oe", 32'(dut1.r_mdio_oe), 32'h0);
    check("reset_bus_z", 32'(mdio), 32'h1);
    check("reset_wr_data2", {11'd0, wr_regad2, wr_data2}, 32'h0);
    @(negedge mdc);
    rst_n = 1'b1;

    // Basic write then read-back of register 0.
    write_frame(32, 5'h01, 5'h00, 2'b10, 16'h8140, wb, wa);
    check("wr0_no_early_pulse", 32'(wb), 32'h0);
    check("wr0_pulse_at_d0", 32'(wa), 32'h1);
    check("wr0_regad", 32'(wr_regad1), 32'h0);
    check("wr0_data", 32'(wr_data1), 32'h8140);
    check("wr0_pulse_count", 32'(wr1), 32'h1);
    read_frame(32, 5'h01, 5'h00, -1, d, ta2, rdp, oe1, oe2);
    check("rd0_ta1_z", 32'(oe1), 32'h0);
    check("rd0_rd_en", 32'(rdp), 32'h1);
    check("rd0_ta2", 32'(ta2), 32'h0);
    check("rd0_data", 32'(d), 32'h8140);
    check("rd0_oe_released", 32'(oe2), 32'h0);

    // Identifier registers.
    read_frame(1, 5'h01, 5'h02, -1, d, ta2, rdp, oe1, oe2);
    check("rd2_ta2", 32'(ta2), 32'h0);
    check("rd2_data", 32'(d), 32'h0022);
    check("rd2_oe_released", 32'(oe2), 32'h0);
    read_frame(1, 5'h01, 5'h03, -1, d, ta2, rdp, oe1, oe2);
    check("rd3_data", 32'(d), 32'h1622);
    check("rd3_oe_released", 32'(oe2), 32'h0);
    check("rd_pulse_count", 32'(rd1), 32'h3);

    // Write to read-only register 3.
    write_frame(1, 5'h01, 5'h03, 2'b10, 16'hFFFF, wb, wa);
    check("wr3_pulse", 32'(wa), 32'h1);
    check("wr3_regad", 32'(wr_regad1), 32'h3);
    check("wr3_data", 32'(wr_data1), 32'hFFFF);
    read_frame(1, 5'h01, 5'h03, -1, d, ta2, rdp, oe1, oe2);
    check("rd3_after_wr", 32'(d), 32'h1622);

    // Foreign PHY address.
    s_drv = drv1; s_wr = wr1; s_rd = rd1; s_err = err1;
    read_frame(32, 5'h07, 5'h00, -1, d, ta2, rdp, oe1, oe2);
    write_frame(32, 5'h07, 5'h00, 2'b10, 16'hFFFF, wb, wa);
    check("foreign_no_drive", 32'(drv1 - s_drv), 32'h0);
    check("foreign_no_wr", 32'(wr1 - s_wr), 32'h0);
    check("foreign_no_rd", 32'(rd1 - s_rd), 32'h0);
    check("foreign_no_err", 32'(err1 - s_err), 32'h0);
    read_frame(1, 5'h01, 5'h00, -1, d, ta2, rdp, oe1, oe2);
    check("after_foreign_rd0", 32'(d), 32'h8140);

    // OP=11 is an error and the remainder of the frame is skipped.
    s_drv = drv1; s_wr = wr1; s_rd = rd1; s_err = err1;
    send_hdr(32, 2'b11, 5'h01, 5'h00);
    release_bus(20);
    check("op11_err", 32'(err1 - s_err), 32'h1);
    check("op11_no_drive", 32'(drv1 - s_drv), 32'h0);
    check("op11_no_rdwr", 32'((rd1 - s_rd) + (wr1 - s_wr)), 32'h0);

    // Write with a bad turnaround.
    s_wr = wr1; s_err = err1;
    write_frame(32, 5'h01, 5'h01, 2'b00, 16'h1234, wb, wa);
    check("bad_ta_err", 32'(err1 - s_err), 32'h1);
    check("bad_ta_no_wr", 32'(wr1 - s_wr), 32'h0);
    read_frame(1, 5'h01, 5'h01, -1, d, ta2, rdp, oe1, oe2);
    check("bad_ta_reg_unchanged", 32'(d), 32'h0000);

    // PRE_BITS=32: 31 ones are not enough, 32 are.
    @(negedge mdc);
    tb_oe = 1'b1;
    tb_o  = 1'b0;
    sel2  = 1'b1;
    s_drv = drv2; s_rd = rd2; s_err = err2;
    read_frame(31, 5'h02, 5'h02, -1, d, ta2, rdp, oe1, oe2);
    @(negedge mdc);
    tb_oe = 1'b1;
    tb_o  = 1'b0;
    check("pre31_no_drive", 32'(drv2 - s_drv), 32'h0);
    check("pre31_no_rd", 32'(rd2 - s_rd), 32'h0);
    check("pre31_no_err", 32'(err2 - s_err), 32'h0);
    read_frame(32, 5'h02, 5'h02, -1, d, ta2, rdp, oe1, oe2);
    check("pre32_rd_en", 32'(rdp), 32'h1);
    check("pre32_data", 32'(d), 32'h0022);
    @(negedge mdc);
    tb_oe = 1'b0;
    sel2  = 1'b0;

    // Reset in the middle of read data.
    read_frame(32, 5'h01, 5'h00, 8, d, ta2, rdp, oe1, oe2);
    check("rst_partial_data", 32'(d[15:7]), 32'(9'b1000_0001_0));
    repeat (2) @(negedge mdc);
    check("rst_wr_data", 32'(wr_data1), 32'h0);
    rst_n = 1'b1;
    read_frame(32, 5'h01, 5'h00, -1, d, ta2, rdp, oe1, oe2);
    check("post_rst_rd0", 32'(d), 32'h0000);
    read_frame(1, 5'h01, 5'h02, -1, d, ta2, rdp, oe1, oe2);
    check("post_rst_rd2", 32'(d), 32'h0022);

    check("pulses_exclusive", 32'(excl), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
